// File: rtl/freq_gate_counter.sv
// freq_gate_counter: counts pulse_in over a GATE_CYCLES gate window and publishes the count.
// Define FREQ_BCD_EN to add a sequential double-dabble BCD image of the result on freq_bcd.
module freq_gate_counter #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 27,
  parameter int unsigned BCD_DIGITS  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             single,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] freq_count,
  output logic             freq_valid,
  output logic             overflow,
`ifdef FREQ_BCD_EN
  output logic [4*BCD_DIGITS-1:0] freq_bcd,
`endif
  output logic             busy
);

  localparam int unsigned TW = $clog2(GATE_CYCLES);
  localparam logic [TW-1:0]    TimerLast = TW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax    = '1;

  if (GATE_CYCLES < 2 || BCD_DIGITS < 1) begin : g_param_check
    $error("freq_gate_counter: GATE_CYCLES must be >= 2 and BCD_DIGITS >= 1");
  end

`ifdef FREQ_BCD_EN
  localparam int unsigned BW = 4 * BCD_DIGITS;
  localparam int unsigned SW = $clog2(CNT_W + 1);
  localparam logic [SW-1:0] StepLast = SW'(CNT_W - 1);
  typedef enum logic [1:0] {StIdle, StGate, StLatch, StConvert} state_e;
`else
  typedef enum logic [1:0] {StIdle, StGate, StLatch} state_e;
`endif

  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  freq_count_q, freq_count_d;
  logic              overflow_q, overflow_d;
  logic              freq_valid_q, freq_valid_d;

`ifdef FREQ_BCD_EN
  logic [CNT_W-1:0]  bin_q, bin_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [BW-1:0]     bcd_adj, bcd_shift;
  logic [BW-1:0]     freq_bcd_q, freq_bcd_d;
  logic [SW-1:0]     step_q, step_d;
  logic              single_q, single_d;

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary MSB.
  // Digits shifted out of the top are lost, which truncates to BCD_DIGITS digits.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_shift = {bcd_adj[BW-2:0], bin_q[CNT_W-1]};
  end
`endif

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    freq_count_d = freq_count_q;
    overflow_d   = overflow_q;
    freq_valid_d = 1'b0;
`ifdef FREQ_BCD_EN
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    step_d       = step_q;
    single_d     = single_q;
    freq_bcd_d   = freq_bcd_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StGate;
          timer_d = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end

      StGate: begin
        if (!enable) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q + TW'(1);
          if (pulse_in) begin
            if (cnt_q == CntMax) begin
              ovf_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          if (timer_q == TimerLast) begin
            state_d = StLatch;
          end
        end
      end

      StLatch: begin
`ifdef FREQ_BCD_EN
        state_d  = StConvert;
        bin_d    = cnt_q;
        bcd_d    = '0;
        step_d   = '0;
        single_d = single;
`else
        freq_count_d = cnt_q;
        overflow_d   = ovf_q;
        freq_valid_d = 1'b1;
        if (enable && !single) begin
          state_d = StGate;
          timer_d = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else begin
          state_d = StIdle;
        end
`endif
      end

`ifdef FREQ_BCD_EN
      StConvert: begin
        bin_d  = bin_q << 1;
        bcd_d  = bcd_shift;
        step_d = step_q + SW'(1);
        if (step_q == StepLast) begin
          freq_bcd_d   = bcd_shift;
          freq_count_d = cnt_q;
          overflow_d   = ovf_q;
          freq_valid_d = 1'b1;
          // single was captured in LATCH; enable is not an abort here.
          if (enable && !single_q) begin
            state_d = StGate;
            timer_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
`endif

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      freq_count_q <= '0;
      overflow_q   <= 1'b0;
      freq_valid_q <= 1'b0;
`ifdef FREQ_BCD_EN
      bin_q        <= '0;
      bcd_q        <= '0;
      step_q       <= '0;
      single_q     <= 1'b0;
      freq_bcd_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      freq_count_q <= freq_count_d;
      overflow_q   <= overflow_d;
      freq_valid_q <= freq_valid_d;
`ifdef FREQ_BCD_EN
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      step_q       <= step_d;
      single_q     <= single_d;
      freq_bcd_q   <= freq_bcd_d;
`endif
    end
  end

  assign freq_count = freq_count_q;
  assign overflow   = overflow_q;
  assign freq_valid = freq_valid_q;
  assign busy       = (state_q != StIdle);
`ifdef FREQ_BCD_EN
  assign freq_bcd   = freq_bcd_q;
`endif

endmodule

// File: tb/tb_freq_gate_counter.sv
// tb_freq_gate_counter: random and directed stimulus traces checked cycle by cycle against
// a window-level reference model; also checks asynchronous reset in the middle of a window.
module tb_freq_gate_counter;

  localparam int G    = 30;
  localparam int CW   = 4;
  localparam int BD   = 2;
  localparam int MAXC = (1 << CW) - 1;
  localparam int N    = 3000;
`ifdef FREQ_BCD_EN
  localparam int X = CW;
`else
  localparam int X = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          single = 1'b0;
  logic          pulse_in = 1'b0;
  logic [CW-1:0] freq_count;
  logic          freq_valid;
  logic          overflow;
  logic          busy;
`ifdef FREQ_BCD_EN
  logic [4*BD-1:0] freq_bcd;
`endif

  freq_gate_counter #(
    .GATE_CYCLES(G),
    .CNT_W      (CW),
    .BCD_DIGITS (BD)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .single    (single),
    .pulse_in  (pulse_in),
    .freq_count(freq_count),
    .freq_valid(freq_valid),
    .overflow  (overflow),
`ifdef FREQ_BCD_EN
    .freq_bcd  (freq_bcd),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Stimulus value at index k is what the DUT samples on trace edge k.
  bit st_en[N];
  bit st_sg[N];
  bit st_pl[N];
  // Expected outputs just after trace edge k.
  bit ex_busy[N];
  bit ex_valid[N];
  int ex_cnt[N];
  bit ex_ovf[N];
  int pub_cnt[N];
  bit pub_ovf[N];

  task automatic check_eq(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

`ifdef FREQ_BCD_EN
  function automatic longint to_bcd(input int value);
    longint r = 0;
    int v = value;
    for (int d = 0; d < BD; d++) begin
      r = r | (longint'(v % 10) << (4 * d));
      v = v / 10;
    end
    return r;
  endfunction
`endif

  task automatic gen_stimulus();
    int  dens = 0;
    bit  en_st = 1'b1;
    bit  sg_st = 1'b0;
    // Single window: pulses on first and last window edge plus the dead LATCH edge.
    for (int i = 3; i <= 33; i++) begin st_en[i] = 1'b1; st_sg[i] = 1'b1; end
    st_pl[4] = 1'b1; st_pl[33] = 1'b1; st_pl[34] = 1'b1;
    // Single window with three pulses.
    for (int i = 40; i <= 70; i++) begin st_en[i] = 1'b1; st_sg[i] = 1'b1; end
    st_pl[45] = 1'b1; st_pl[50] = 1'b1; st_pl[60] = 1'b1;
    // Aborted window: enable drops on gate edge 5.
    for (int i = 80; i <= 84; i++) begin st_en[i] = 1'b1; st_sg[i] = 1'b1; end
    st_pl[81] = 1'b1; st_pl[82] = 1'b1;
    // Continuous: saturating window, then a two-pulse window.
    for (int i = 100; i <= 170; i++) st_en[i] = 1'b1;
    for (int i = 101; i <= 120; i++) st_pl[i] = 1'b1;
    st_pl[140] = 1'b1; st_pl[150] = 1'b1;
    for (int i = 200; i < N; i++) begin
      if (i % 64 == 0) begin
        case ($urandom_range(4))
          0: dens = 0;
          1: dens = 10;
          2: dens = 40;
          3: dens = 70;
          default: dens = 100;
        endcase
      end
      if (i >= N - 100) en_st = 1'b0;
      else if (en_st && $urandom_range(59) == 0) en_st = 1'b0;
      else if (!en_st && $urandom_range(4) == 0) en_st = 1'b1;
      if ($urandom_range(99) == 0) sg_st = !sg_st;
      st_en[i] = en_st;
      st_sg[i] = sg_st;
      st_pl[i] = ($urandom_range(99) < dens);
    end
  endtask

  // Walk the trace window by window: start edge t, window edges t+1..t+G,
  // publish on edge t+G+1+X, restart there if enabled and not single.
  task automatic build_expect();
    int k = 0;
    int sum, t, e, p, cur_c;
    bit abort, s, cur_o;
    for (int i = 0; i < N; i++) begin
      ex_busy[i] = 1'b0; ex_valid[i] = 1'b0; pub_cnt[i] = 0; pub_ovf[i] = 1'b0;
    end
    while (k < N) begin
      if (!st_en[k]) begin
        k++;
        continue;
      end
      t = k;
      ex_busy[t] = 1'b1;
      sum = 0;
      abort = 1'b0;
      for (int j = 1; j <= G; j++) begin
        e = t + j;
        if (e >= N) begin abort = 1'b1; k = N; break; end
        if (!st_en[e]) begin abort = 1'b1; k = e + 1; break; end
        ex_busy[e] = 1'b1;
        sum += int'(st_pl[e]);
      end
      if (abort) continue;
      p = t + G + 1 + X;
      if (p >= N) begin
        for (int i = t + G + 1; i < N; i++) ex_busy[i] = 1'b1;
        k = N;
        continue;
      end
      for (int i = t + G + 1; i < p; i++) ex_busy[i] = 1'b1;
      s = st_sg[t + G + 1];
      ex_valid[p] = 1'b1;
      pub_cnt[p]  = (sum > MAXC) ? MAXC : sum;
      pub_ovf[p]  = (sum > MAXC);
      k = (st_en[p] && !s) ? p : p + 1;
    end
    cur_c = 0;
    cur_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (ex_valid[i]) begin cur_c = pub_cnt[i]; cur_o = pub_ovf[i]; end
      ex_cnt[i] = cur_c;
      ex_ovf[i] = cur_o;
    end
  endtask

  initial begin
    gen_stimulus();
    build_expect();

    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_busy", busy, 0);
    check_eq("reset_valid", freq_valid, 0);
    check_eq("reset_count", freq_count, 0);
    check_eq("reset_ovf", overflow, 0);
`ifdef FREQ_BCD_EN
    check_eq("reset_bcd", freq_bcd, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      enable   = st_en[k];
      single   = st_sg[k];
      pulse_in = st_pl[k];
      @(posedge clk);
      #1;
      check_eq($sformatf("busy@%0d", k), busy, ex_busy[k]);
      check_eq($sformatf("valid@%0d", k), freq_valid, ex_valid[k]);
      check_eq($sformatf("count@%0d", k), freq_count, ex_cnt[k]);
      check_eq($sformatf("ovf@%0d", k), overflow, ex_ovf[k]);
`ifdef FREQ_BCD_EN
      check_eq($sformatf("bcd@%0d", k), freq_bcd, to_bcd(ex_cnt[k]));
`endif
    end

    // Asynchronous reset during gate cycle 4 of a running window.
    @(negedge clk);
    enable   = 1'b1;
    single   = 1'b0;
    pulse_in = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_valid", freq_valid, 0);
    check_eq("midrst_count", freq_count, 0);
    check_eq("midrst_ovf", overflow, 0);
    @(negedge clk);
    enable   = 1'b0;
    pulse_in = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("post_rst_busy%0d", i), busy, 0);
      check_eq($sformatf("post_rst_valid%0d", i), freq_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/freq_gate_counter.md
Name: freq_gate_counter

Overview:
- Downstream consumer of the one-shot edge detector in the frequency meter.
- Counts single-cycle pulses on `pulse_in` over a fixed gate window of `GATE_CYCLES` clock cycles.
- Latches the result as the measured frequency and flags it with a one-cycle `freq_valid`.
- Supports single-shot or continuous measurement; the counter saturates on overflow.

Parameters:
- GATE_CYCLES, 50_000_000, gate window length in clk cycles (1 s at 50 MHz); legal range >= 2.
- CNT_W, 27, width of the pulse counter and of `freq_count`.
- BCD_DIGITS, 8, number of BCD digits on `freq_bcd` (used only with FREQ_BCD_EN).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  1 = run measurements; 0 = stop or abort.
- single  input  1  1 = stop after one window; 0 = continuous windows.
- pulse_in  input  1  one-cycle event pulse from the one-shot, synchronous to clk.
- freq_count  output  CNT_W  pulses counted in the last completed window.
- freq_valid  output  1  one-cycle strobe when freq_count/overflow are updated.
- overflow  output  1  last completed window saturated.
- busy  output  1  1 in any state other than IDLE.
- freq_bcd  output  4*BCD_DIGITS  BCD image of freq_count; present only with FREQ_BCD_EN.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - freq_count=0, freq_valid=0, overflow=0, busy=0, freq_bcd=0.
  - Gate timer and pulse counter = 0.
- Timer width is clog2(GATE_CYCLES). `pulse_in` is counted on every cycle it is 1; the block does no edge detection itself.
- States: IDLE, GATE, LATCH, plus CONVERT with FREQ_BCD_EN.
- IDLE:
  - busy=0.
  - enable=1 sampled at edge t -> GATE, with timer=0, counter=0, internal ovf=0.
- GATE:
  - busy=1. Timer increments each cycle. counter += pulse_in.
  - At 2^CNT_W-1 the counter holds and internal ovf is set.
  - The window is exactly GATE_CYCLES cycles: t+1 .. t+GATE_CYCLES. A pulse on the last window cycle is counted.
  - When timer == GATE_CYCLES-1 -> LATCH.
  - enable=0 in any GATE cycle -> IDLE next cycle. No freq_valid; freq_count, overflow and freq_bcd keep their previous values.
- LATCH (one cycle, without BCD):
  - freq_count<=counter and overflow<=ovf.
  - freq_valid=1 in the cycle after LATCH, i.e. cycle t+GATE_CYCLES+1 relative to enable sampling, for exactly one cycle.
  - Next state: enable=1 and single=0 -> GATE (timer, counter, ovf cleared); otherwise -> IDLE.
  - `pulse_in` in the LATCH cycle is dropped (dead time = 1 cycle per window).
- Outputs are registered; freq_count and overflow are stable between freq_valid strobes.
- `single` is sampled only in LATCH; changing it mid-window has no effect on the current window.
- enable=0 during LATCH: the result is still published, then -> IDLE.

Optional Feature:
- Macro: FREQ_BCD_EN.
- Defined:
  - The `freq_bcd` port exists.
  - LATCH -> CONVERT. CONVERT runs a sequential shift-add-3 (double-dabble) conversion of the latched count, one bit per cycle, CNT_W cycles.
  - freq_bcd and freq_valid update together on completion, so freq_valid arrives CNT_W cycles later than the non-BCD case.
  - busy stays 1 during CONVERT.
  - Continuous mode re-enters GATE only after CONVERT finishes; pulses during CONVERT are dropped.
  - Digits above BCD_DIGITS are truncated.
  - enable=0 during CONVERT does not abort; the result is published, then -> IDLE.
- Not defined:
  - No freq_bcd port and no CONVERT state.
  - Timing exactly as in Behaviour.

Test Plan:
- Reset mid-operation: GATE_CYCLES=10, enable=1 with pulses, assert rst_n=0 in gate cycle 4 -> all outputs 0 immediately, state IDLE; after release with enable=0, busy stays 0.
- Single window: GATE_CYCLES=10, single=1, enable at edge t, 3 pulses in the window -> freq_count=3, overflow=0, freq_valid=1 only at cycle t+11, then busy=0.
- Window edges: pulses at gate cycle 1, gate cycle 10 and the LATCH cycle -> freq_count=2.
- Continuous mode: single=0, pulses 4/window for 3 windows -> three freq_valid strobes spaced 11 cycles apart, each freq_count=4.
- Overflow: CNT_W=4, GATE_CYCLES=30, pulse_in held 1 for 20 cycles -> freq_count=15, overflow=1; the next window with 2 pulses -> freq_count=2, overflow=0.
- Abort and BCD:
  - Prior result 7; enable dropped at gate cycle 5 -> no freq_valid, freq_count=7.
  - With FREQ_BCD_EN, count 1234 -> freq_bcd=0x00001234 with freq_valid CNT_W cycles after LATCH.
